// File: rtl/y86_fetch_seq.sv
// Byte-serial Y86-64 instruction fetch for the SEQ datapath.
// Reads one instruction byte per req/ack handshake. It decodes the length from the icode and
// assembles icode/ifun/rA/rB/valC/valP.
module y86_fetch_seq #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  output logic        busy,
  output logic        done,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error
);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e      st_q, st_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;
  logic        ivalid_q, ivalid_d;
  logic        err_q, err_d;

  // Total instruction length in bytes; undefined icodes occupy one byte.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    has_reg = (ic >= 4'h2 && ic <= 4'h6) || ic == 4'hA || ic == 4'hB;
  endfunction

  // Byte index of the first constant byte, 0 when there is no constant.
  function automatic logic [3:0] const_base(input logic [3:0] ic);
    case (ic)
      4'h7, 4'h8:       const_base = 4'd1;
      4'h3, 4'h4, 4'h5: const_base = 4'd2;
      default:          const_base = 4'd0;
    endcase
  endfunction

  logic [64:0] addr_sum;
  logic [63:0] addr;
  logic        addr_bad;
  logic [3:0]  cur_ic;
  logic [3:0]  cur_len;
  logic [3:0]  cbase;
  logic [3:0]  kidx;

  // Current byte address with overflow-aware range check; byte 0 decodes straight off the bus.
  always_comb begin
    addr_sum = {1'b0, pc_q} + {61'b0, idx_q};
    addr     = addr_sum[63:0];
    addr_bad = addr_sum[64] | (addr >= 64'(MEM_BYTES));
    cur_ic   = (idx_q == 4'd0) ? mem_rdata[7:4] : icode_q;
    cur_len  = instr_len(cur_ic);
    cbase    = const_base(cur_ic);
    kidx     = idx_q - cbase;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    valp_d   = valp_q;
    ivalid_d = ivalid_q;
    err_d    = err_q;
    mem_req  = 1'b0;
    mem_addr = addr;
    busy     = (st_q != StIdle);
    done     = (st_q == StDone);
    unique case (st_q)
      StIdle: begin
        if (start) begin
          pc_d     = pc;
          idx_d    = 4'd0;
          err_d    = 1'b0;
          valc_d   = 64'd0;
          icode_d  = 4'h0;
          ifun_d   = 4'h0;
          ra_d     = 4'hF;
          rb_d     = 4'hF;
          ivalid_d = 1'b1;
          st_d     = StFetch;
        end
      end
      StFetch: begin
        if (addr_bad) begin
          // Abort without ever presenting the bad address to memory.
          err_d  = 1'b1;
          valp_d = addr;
          st_d   = StDone;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            if (mem_err) begin
              err_d  = 1'b1;
              valp_d = addr;
              st_d   = StDone;
            end else begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd0) begin
                icode_d  = mem_rdata[7:4];
                ifun_d   = mem_rdata[3:0];
                ivalid_d = (mem_rdata[7:4] <= 4'hB);
              end
              if (has_reg(cur_ic) && idx_q == 4'd1) begin
                ra_d = mem_rdata[7:4];
                rb_d = mem_rdata[3:0];
              end
              if (cbase != 4'd0 && idx_q >= cbase) begin
                valc_d[{kidx[2:0], 3'b000} +: 8] = mem_rdata;
              end
              if (idx_q == cur_len - 4'd1) begin
                valp_d = pc_q + 64'(cur_len);
                st_d   = StDone;
              end
            end
          end
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StIdle;
      pc_q     <= 64'd0;
      idx_q    <= 4'd0;
      icode_q  <= 4'h0;
      ifun_q   <= 4'h0;
      ra_q     <= 4'hF;
      rb_q     <= 4'hF;
      valc_q   <= 64'd0;
      valp_q   <= 64'd0;
      ivalid_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      valc_q   <= valc_d;
      valp_q   <= valp_d;
      ivalid_q <= ivalid_d;
      err_q    <= err_d;
    end
  end

  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign instr_valid = ivalid_q;
  assign imem_error  = err_q;

endmodule

// File: tb/tb_y86_fetch_seq.sv
// Randomised scoreboard bench for y86_fetch_seq with a byte-array memory model.
module tb_y86_fetch_seq;
  localparam int unsigned MEM = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic [63:0] pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;
  logic        busy, done;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp;
  logic        instr_valid, imem_error;

  y86_fetch_seq #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy), .done(done), .icode(icode), .ifun(ifun), .rA(ra), .rB(rb),
    .valC(valc), .valP(valp), .instr_valid(instr_valid), .imem_error(imem_error)
  );

  always #5 clk = ~clk;

  // Memory model: fixed wait states per byte, optional fault at one address.
  logic [7:0]  mem [MEM];
  int unsigned waits;
  int unsigned wcnt;
  logic        err_en;
  logic [63:0] err_addr;

  always @(posedge clk) begin
    if (rst || !mem_req) wcnt <= waits;
    else if (!mem_ack) wcnt <= wcnt - 1;
    else wcnt <= waits;
  end
  assign mem_ack   = (wcnt == 0);
  assign mem_rdata = mem[mem_addr[11:0]];
  assign mem_err   = err_en && (mem_addr == err_addr);

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        ivalid, err, chk_valp;
    int          lat;
    int          nacc;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] acc_q[$];
  int          nvec = 0;
  int          nbad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  // Reference: walk the instruction bytes, stop at the first fault, assemble fields.
  function automatic exp_t model(input logic [63:0] p, input logic [7:0] b [10],
                                 input int err_idx, input int w);
    exp_t e;
    int len, stop, cb;
    logic oor, fe;
    logic [3:0] ic;
    ic = b[0][7:4];
    len = ilen(ic);
    stop = len; oor = 0; fe = 0;
    for (int i = 0; i < len; i++) begin
      if (p + 64'(i) >= 64'(MEM)) begin stop = i; oor = 1; break; end
      if (i == err_idx) begin stop = i; fe = 1; break; end
    end
    e.pc = p;
    e.icode = ic;
    e.ifun = b[0][3:0];
    e.ivalid = (ic <= 4'hB);
    e.ra = 4'hF; e.rb = 4'hF;
    if ((ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) && stop > 1) begin
      e.ra = b[1][7:4]; e.rb = b[1][3:0];
    end
    cb = (ic == 4'h7 || ic == 4'h8) ? 1 : (ic >= 4'h3 && ic <= 4'h5) ? 2 : 0;
    e.valc = 64'd0;
    if (cb != 0)
      for (int k = 0; k < 8; k++)
        if (cb + k < stop) e.valc = e.valc | (64'(b[cb + k]) << (8 * k));
    e.err = oor | fe;
    e.valp = (oor | fe) ? p + 64'(stop) : p + 64'(len);
    e.chk_valp = !oor;
    e.lat = stop * (w + 1) + (fe ? w + 1 : 0) + (oor ? 1 : 0) + 1;
    e.nacc = stop + (fe ? 1 : 0);
    return e;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Monitor: bus checks every cycle, scoreboard compare on each done pulse.
  initial begin
    logic        prev_wait;
    logic [63:0] prev_addr;
    exp_t        e;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
        acc_q.delete();
      end else begin
        if (mem_req) begin
          chk("addr_in_range", 64'(mem_addr < 64'(MEM)), 64'd1);
          if (prev_wait) chk("addr_stable", mem_addr, prev_addr);
          if (mem_ack) acc_q.push_back(mem_addr);
        end
        prev_wait = mem_req && !mem_ack;
        prev_addr = mem_addr;
        if (done) begin
          done_cnt++;
          if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("icode", 64'(icode), 64'(e.icode));
            chk("ifun", 64'(ifun), 64'(e.ifun));
            chk("rA", 64'(ra), 64'(e.ra));
            chk("rB", 64'(rb), 64'(e.rb));
            chk("valC", valc, e.valc);
            if (e.chk_valp) chk("valP", valp, e.valp);
            chk("instr_valid", 64'(instr_valid), 64'(e.ivalid));
            chk("imem_error", 64'(imem_error), 64'(e.err));
            chk("busy_in_done", 64'(busy), 64'd1);
            chk("latency", 64'(cyc - start_cyc + 1), 64'(e.lat));
            chk("bytes_fetched", 64'(acc_q.size()), 64'(e.nacc));
            for (int i = 0; i < acc_q.size() && i < e.nacc; i++)
              chk("fetch_addr", acc_q[i], e.pc + 64'(i));
          end
          acc_q.delete();
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_icode"}, 64'(icode), 64'd0);
    chk({tag, "_ifun"}, 64'(ifun), 64'd0);
    chk({tag, "_rA"}, 64'(ra), 64'hF);
    chk({tag, "_rB"}, 64'(rb), 64'hF);
    chk({tag, "_valC"}, valc, 64'd0);
    chk({tag, "_valP"}, valp, 64'd0);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd1);
    chk({tag, "_imem_error"}, 64'(imem_error), 64'd0);
  endtask

  task automatic load(input logic [63:0] p, input logic [7:0] b [10]);
    logic [63:0] a;
    for (int i = 0; i < 10; i++) begin
      a = p + 64'(i);
      if (a < 64'(MEM)) mem[a[11:0]] = b[i];
    end
  endtask

  // Issue one fetch, push its expectation, wait (bounded) for the done pulse.
  task automatic run(input logic [63:0] p, input logic [7:0] b [10], input int w,
                     input int err_idx, input bit glitch);
    int d0;
    int t;
    load(p, b);
    waits = w;
    err_en = (err_idx >= 0);
    err_addr = p + 64'(err_idx);
    sbq.push_back(model(p, b, err_idx, w));
    pc = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      if (glitch && t == 2) begin pc = p + 64'h40; start = 1'b1; end
      if (glitch && t == 3) start = 1'b0;
      @(posedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      chk("done_timeout", 64'd0, 64'd1);
      sbq.delete();
    end
    err_en = 1'b0;
  endtask

  initial begin
    logic [7:0]  b [10];
    logic [63:0] p;
    int          ei, w, len, r;
    logic [3:0]  ic;
    start = 1'b0; pc = '0; waits = 0; err_en = 1'b0; err_addr = '0;
    for (int i = 0; i < MEM; i++) mem[i] = 8'h00;
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    b = '{8'h30, 8'hF3, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(64'h100, b, 0, -1, 1'b0);
    b = '{8'h73, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(64'h10, b, 0, -1, 1'b0);
    b = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(64'h40, b, 0, -1, 1'b0);
    b = '{8'h60, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(64'h80, b, 3, -1, 1'b1);
    b = '{8'hC5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(64'h90, b, 0, -1, 1'b0);
    b = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run(64'h200, b, 0, 3, 1'b0);
    b = '{8'h30, 8'hF1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run(64'(MEM - 2), b, 0, -1, 1'b0);

    // Reset in the middle of a call fetch, then a clean fetch afterwards.
    b = '{8'h80, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(64'h300, b);
    waits = 0;
    pc = 64'h300;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run(64'h300, b, 0, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ic = 4'($urandom_range(0, 15));
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
      b[0][7:4] = ic;
      w = $urandom_range(0, 2);
      len = ilen(ic);
      p = 64'($urandom_range(0, MEM - 16));
      ei = -1;
      r = $urandom_range(0, 4);
      if (len >= 3 && r == 0) ei = $urandom_range(2, len - 1);
      else if (len >= 3 && r == 1) p = 64'(MEM - $urandom_range(2, len - 1));
      run(p, b, w, ei, 1'b0);
    end

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
